// File: rtl/parking_pkg.sv
// Shared parking definitions: FSM state encoding, active-low 7-seg glyphs
// (segment order gfedcba) and the token compare helper.
package parking_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_WAIT_TOKEN  = 3'd1,
    ST_WRONG_TOKEN = 3'd2,
    ST_GATE_OPEN   = 3'd3,
    ST_LOCKOUT     = 3'd4,
    ST_TAILGATE    = 3'd5
  } state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [6:0] SEG_E   = 7'h06;
  localparam logic [6:0] SEG_T   = 7'h07;
  localparam logic [6:0] SEG_6   = 7'h02;
  localparam logic [6:0] SEG_0   = 7'h40;
  localparam logic [6:0] SEG_L   = 7'h47;
  localparam logic [6:0] SEG_5   = 7'h12;
  localparam logic [6:0] SEG_P   = 7'h0C;

  function automatic logic token_match(input logic [1:0] t1, input logic [1:0] t2,
                                       input logic [1:0] exp1, input logic [1:0] exp2);
    return (t1 == exp1) && (t2 == exp2);
  endfunction

endpackage

// File: rtl/occupancy_counter.sv
// Saturating occupancy counter shared by entrance and exit sides; full is
// registered alongside the count so both change on the same edge.
module occupancy_counter #(
  parameter int CAPACITY = 8,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);

  logic [CNT_W-1:0] count_nxt;

  // Simultaneous inc and dec cancel, even at the saturation limits.
  always_comb begin
    count_nxt = count;
    if (inc && !dec) begin
      if (count != CAP) count_nxt = count + CNT_W'(1);
    end else if (dec && !inc) begin
      if (count != '0) count_nxt = count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      full  <= 1'b0;
    end else begin
      count <= count_nxt;
      full  <= (count_nxt == CAP);
    end
  end

endmodule

// File: rtl/parking_exit_controller.sv
// Exit gate controller: token check, retry/lockout, tailgate handling and the
// shared occupancy count. Define EXIT_HEX_EN to drive per-state HEX glyphs.
module parking_exit_controller
  import parking_pkg::*;
#(
  parameter int         WAIT_CYCLES = 4,
  parameter int         MAX_TRIES   = 3,
  parameter int         LOCK_CYCLES = 16,
  parameter int         CAPACITY    = 8,
  parameter int         CNT_W       = 4,
  parameter logic [1:0] TOKEN_1     = 2'b10,
  parameter logic [1:0] TOKEN_2     = 2'b01
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sensor_exit,
  input  logic             sensor_clear,
  input  logic [1:0]       token_1,
  input  logic [1:0]       token_2,
  input  logic             token_valid,
  input  logic             car_entered,
  output logic             GREEN_LED,
  output logic             RED_LED,
  output logic             gate_open,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic [6:0]       HEX_1,
  output logic [6:0]       HEX_2
);

  localparam int WAIT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam int TRY_W  = $clog2(MAX_TRIES + 1);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_CYCLES - 1);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);
  localparam logic [TRY_W-1:0]  TRY_MAX   = TRY_W'(MAX_TRIES);

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic [LOCK_W-1:0] lock_cnt, lock_nxt;
  logic [TRY_W-1:0]  tries, tries_nxt;
  logic              blink;
  logic              blink_state;
  logic              exit_pulse;
  logic              match;

  assign match = token_match(token_1, token_2, TOKEN_1, TOKEN_2);

  always_comb begin
    state_nxt  = state;
    tries_nxt  = tries;
    exit_pulse = 1'b0;
    case (state)
      ST_IDLE: begin
        tries_nxt = '0;
        if (sensor_exit && occupancy != '0) state_nxt = ST_WAIT_TOKEN;
      end
      ST_WAIT_TOKEN: begin
        if (!sensor_exit) begin
          state_nxt = ST_IDLE;
        end else if (wait_cnt == WAIT_LAST) begin
          if (match) begin
            state_nxt = ST_GATE_OPEN;
          end else begin
            tries_nxt = TRY_W'(1);
            state_nxt = (tries_nxt == TRY_MAX) ? ST_LOCKOUT : ST_WRONG_TOKEN;
          end
        end
      end
      ST_WRONG_TOKEN: begin
        if (token_valid) begin
          if (match) begin
            state_nxt = ST_GATE_OPEN;
          end else begin
            tries_nxt = (tries == TRY_MAX) ? tries : tries + TRY_W'(1);
            if (tries_nxt == TRY_MAX) state_nxt = ST_LOCKOUT;
          end
        end
      end
      ST_LOCKOUT: begin
        if (lock_cnt == LOCK_LAST) begin
          state_nxt = ST_WRONG_TOKEN;
          tries_nxt = '0;
        end
      end
      ST_GATE_OPEN: begin
        tries_nxt = '0;
        if (sensor_clear) begin
          if (sensor_exit) begin
            state_nxt = ST_TAILGATE;
          end else begin
            state_nxt  = ST_IDLE;
            exit_pulse = 1'b1;
          end
        end
      end
      ST_TAILGATE: begin
        if (token_valid && match) state_nxt = ST_GATE_OPEN;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Dwell counters restart whenever their state is (re)entered.
  assign wait_nxt = (state == ST_WAIT_TOKEN && state_nxt == ST_WAIT_TOKEN) ? wait_cnt + WAIT_W'(1) : '0;
  assign lock_nxt = (state == ST_LOCKOUT && state_nxt == ST_LOCKOUT) ? lock_cnt + LOCK_W'(1) : '0;

  assign blink_state = (state == ST_GATE_OPEN) || (state == ST_WRONG_TOKEN) || (state == ST_TAILGATE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      lock_cnt <= '0;
      tries    <= '0;
      blink    <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      lock_cnt <= lock_nxt;
      tries    <= tries_nxt;
      blink    <= (blink_state && state_nxt == state) ? ~blink : 1'b0;
    end
  end

  assign gate_open = (state == ST_GATE_OPEN);
  assign GREEN_LED = blink && (state == ST_GATE_OPEN);
  assign RED_LED   = (state == ST_WAIT_TOKEN) || (state == ST_LOCKOUT) ||
                     (blink && (state == ST_WRONG_TOKEN || state == ST_TAILGATE));

  occupancy_counter #(
    .CAPACITY (CAPACITY),
    .CNT_W    (CNT_W)
  ) u_occ (
    .clk   (clk),
    .reset (reset),
    .inc   (car_entered),
    .dec   (exit_pulse),
    .count (occupancy),
    .full  (full)
  );

`ifdef EXIT_HEX_EN
  logic [6:0] hex1_d, hex2_d, hex1_q, hex2_q;

  always_comb begin
    hex1_d = SEG_OFF;
    hex2_d = SEG_OFF;
    case (state)
      ST_WAIT_TOKEN:  begin hex1_d = SEG_E; hex2_d = SEG_T; end
      ST_WRONG_TOKEN: begin hex1_d = SEG_E; hex2_d = SEG_E; end
      ST_GATE_OPEN:   begin hex1_d = SEG_6; hex2_d = SEG_0; end
      ST_LOCKOUT:     begin hex1_d = SEG_L; hex2_d = SEG_0; end
      ST_TAILGATE:    begin hex1_d = SEG_5; hex2_d = SEG_P; end
      default:        begin hex1_d = SEG_OFF; hex2_d = SEG_OFF; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hex1_q <= SEG_OFF;
      hex2_q <= SEG_OFF;
    end else begin
      hex1_q <= hex1_d;
      hex2_q <= hex2_d;
    end
  end

  assign HEX_1 = hex1_q;
  assign HEX_2 = hex2_q;
`else
  assign HEX_1 = SEG_OFF;
  assign HEX_2 = SEG_OFF;
`endif

endmodule

// File: tb/tb_parking_exit_controller.sv
// Directed self-checking bench for parking_exit_controller (default parameters).
module tb_parking_exit_controller;

  logic       clk = 1'b0;
  logic       reset, sensor_exit, sensor_clear, token_valid, car_entered;
  logic [1:0] token_1, token_2;
  logic       GREEN_LED, RED_LED, gate_open, full;
  logic [3:0] occupancy;
  logic [6:0] HEX_1, HEX_2;

  int n_chk = 0;
  int n_err = 0;

  parking_exit_controller dut (
    .clk          (clk),
    .reset        (reset),
    .sensor_exit  (sensor_exit),
    .sensor_clear (sensor_clear),
    .token_1      (token_1),
    .token_2      (token_2),
    .token_valid  (token_valid),
    .car_entered  (car_entered),
    .GREEN_LED    (GREEN_LED),
    .RED_LED      (RED_LED),
    .gate_open    (gate_open),
    .occupancy    (occupancy),
    .full         (full),
    .HEX_1        (HEX_1),
    .HEX_2        (HEX_2)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic enter_cars(input int n);
    car_entered = 1'b1;
    repeat (n) step();
    car_entered = 1'b0;
  endtask

  // From IDLE with a car present: one edge into WAIT_TOKEN, four cycles there.
  task automatic to_gate();
    token_1 = 2'b10; token_2 = 2'b01; sensor_exit = 1'b1;
    repeat (5) step();
  endtask

  initial begin
    reset = 1'b1; sensor_exit = 1'b0; sensor_clear = 1'b0; token_valid = 1'b0;
    car_entered = 1'b0; token_1 = 2'b00; token_2 = 2'b00;
    repeat (2) step();
    reset = 1'b0;
    check("rst_gate", gate_open, 0);
    check("rst_green", GREEN_LED, 0);
    check("rst_red", RED_LED, 0);
    check("rst_occ", occupancy, 0);
    check("rst_full", full, 0);
    check("rst_hex1", HEX_1, 7'h7F);
    check("rst_hex2", HEX_2, 7'h7F);

    // Phantom car: empty lot stays IDLE.
    sensor_exit = 1'b1;
    repeat (3) step();
    check("phantom_red", RED_LED, 0);
    check("phantom_gate", gate_open, 0);
    sensor_exit = 1'b0;

    // Normal exit.
    enter_cars(2);
    check("t1_occ2", occupancy, 2);
    token_1 = 2'b10; token_2 = 2'b01; sensor_exit = 1'b1;
    step();
    check("t1_wait_red", RED_LED, 1);
    repeat (3) step();
    check("t1_wait_last_gate", gate_open, 0);
    step();
    check("t1_gate", gate_open, 1);
    check("t1_green0", GREEN_LED, 0);
    step();
    check("t1_green1", GREEN_LED, 1);
`ifdef EXIT_HEX_EN
    check("t1_hex1", HEX_1, 7'h02);
    check("t1_hex2", HEX_2, 7'h40);
`endif
    step();
    check("t1_green2", GREEN_LED, 0);
    sensor_exit = 1'b0; sensor_clear = 1'b1;
    step();
    sensor_clear = 1'b0;
    check("t1_idle_gate", gate_open, 0);
    check("t1_occ1", occupancy, 1);

    // Car backs off before the token sample.
    token_1 = 2'b00; token_2 = 2'b00; sensor_exit = 1'b1;
    step();
    check("drop_wait_red", RED_LED, 1);
    sensor_exit = 1'b0;
    step();
    check("drop_idle_red", RED_LED, 0);

    // Wrong tokens into lockout.
    sensor_exit = 1'b1;
    repeat (5) step();
    check("t2_wrong_red0", RED_LED, 0);
    check("t2_wrong_gate", gate_open, 0);
    step();
    check("t2_wrong_red1", RED_LED, 1);
`ifdef EXIT_HEX_EN
    check("t6_hex1_E", HEX_1, 7'h06);
    check("t6_hex2_E", HEX_2, 7'h06);
`else
    check("t6_hex1_off", HEX_1, 7'h7F);
    check("t6_hex2_off", HEX_2, 7'h7F);
`endif
    token_valid = 1'b1;
    step();
    check("t2_try2_red", RED_LED, 0);
    step();
    token_valid = 1'b0;
    check("t2_lock_red", RED_LED, 1);
    token_1 = 2'b10; token_2 = 2'b01; token_valid = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      check("t2_lock_hold_red", RED_LED, 1);
      check("t2_lock_hold_gate", gate_open, 0);
    end
`ifdef EXIT_HEX_EN
    check("t2_hex_L", HEX_1, 7'h47);
`endif
    token_valid = 1'b0;
    step();
    check("t2_unlock_red", RED_LED, 0);
    check("t2_unlock_gate", gate_open, 0);
    // tries was cleared: one more mismatch must not relock.
    token_1 = 2'b00; token_2 = 2'b00; token_valid = 1'b1;
    step();
    token_valid = 1'b0;
    step();
    check("t2_tries_cleared", RED_LED, 0);
    token_1 = 2'b10; token_2 = 2'b01; token_valid = 1'b1;
    step();
    token_valid = 1'b0;
    check("t2_reopen_gate", gate_open, 1);
    sensor_exit = 1'b0; sensor_clear = 1'b1;
    step();
    sensor_clear = 1'b0;
    check("t2_occ0", occupancy, 0);

    // Tailgater.
    enter_cars(2);
    to_gate();
    check("t3_gate", gate_open, 1);
    sensor_clear = 1'b1;
    step();
    sensor_clear = 1'b0;
    check("t3_tail_gate", gate_open, 0);
    check("t3_tail_occ", occupancy, 2);
    step();
`ifdef EXIT_HEX_EN
    check("t3_hex_5", HEX_1, 7'h12);
    check("t3_hex_P", HEX_2, 7'h0C);
`endif
    token_valid = 1'b1;
    step();
    token_valid = 1'b0;
    check("t3_reopen", gate_open, 1);
    check("t3_reopen_occ", occupancy, 2);
    sensor_exit = 1'b0; sensor_clear = 1'b1;
    step();
    sensor_clear = 1'b0;
    step();
    check("t3_occ1", occupancy, 1);

    // Capacity saturation.
    enter_cars(7);
    check("t4_occ8", occupancy, 8);
    check("t4_full", full, 1);
    enter_cars(1);
    check("t4_drop", occupancy, 8);
    to_gate();
    sensor_exit = 1'b0; sensor_clear = 1'b1; car_entered = 1'b1;
    step();
    sensor_clear = 1'b0; car_entered = 1'b0;
    check("t4_both_occ", occupancy, 8);
    check("t4_both_full", full, 1);
    check("t4_both_idle", gate_open, 0);

    // Reset while the gate is open.
    to_gate();
    step();
    check("t5_pre_gate", gate_open, 1);
    check("t5_pre_green", GREEN_LED, 1);
    reset = 1'b1;
    step();
    reset = 1'b0; sensor_exit = 1'b0;
    check("t5_gate", gate_open, 0);
    check("t5_green", GREEN_LED, 0);
    check("t5_red", RED_LED, 0);
    check("t5_occ", occupancy, 0);
    check("t5_full", full, 0);
    check("t5_hex1", HEX_1, 7'h7F);
    check("t5_hex2", HEX_2, 7'h7F);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
